// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues word reads to a synchronous
// instruction memory, buffers returned words in a 2-entry FIFO and presents
// the head (with its decoded R-type fields) under a valid/ready handshake.
`timescale 1ns/1ps

module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [5:0]  Op,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  Func
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg;
    logic [1:0]  count_reg;
    logic        inflight_reg;   // a request was accepted last cycle: imem_rdata is live now
    logic        drop_reg;
    logic [31:0] buf_instr_reg [BUF_DEPTH];
    logic [31:0] buf_pc_reg    [BUF_DEPTH];
    logic [31:0] resp_pc_reg;    // address belonging to the word now on imem_rdata

    logic        pop;
    logic        push;
    logic        shift;
    logic [2:0]  occupancy;
    logic [1:0]  wr_idx;
    logic [31:0] redirect_pc_aligned;

    assign redirect_pc_aligned = redirect_pc & ~32'h3;

    assign out_valid = (count_reg != 2'd0);
    assign pop       = out_valid & out_ready;

    // Occupancy after this cycle's pop, counting the word still in flight
    assign occupancy = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    assign imem_req  = (state_reg == RUN) & fetch_en & ~redirect_valid
                       & (occupancy < 3'(BUF_DEPTH));
    assign imem_addr = pc_reg;

    // A redirect flushes the buffer, so neither push nor shift happen in that cycle
    assign push   = inflight_reg & ~drop_reg & ~redirect_valid;
    assign shift  = pop & ~redirect_valid;
    assign wr_idx = count_reg - {1'b0, shift};

    // Head presentation, forced to zero while the buffer is empty
    assign out_instr = out_valid ? buf_instr_reg[0] : 32'h0;
    assign out_pc    = out_valid ? buf_pc_reg[0]    : 32'h0;
    assign Op        = out_instr[31:26];
    assign rs        = out_instr[25:21];
    assign rt        = out_instr[20:16];
    assign rd        = out_instr[15:11];
    assign shamt     = out_instr[10:6];
    assign Func      = out_instr[5:0];

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    // FSM next state: fetch_en alone moves between IDLE and RUN
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (fetch_en)  state_next = RUN;
            RUN:     if (!fetch_en) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // PC, occupancy and in-flight tracking; redirect has top priority
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_reg       <= RESET_PC;
            count_reg    <= 2'd0;
            inflight_reg <= 1'b0;
            drop_reg     <= 1'b0;
            resp_pc_reg  <= 32'h0;
        end else begin
            inflight_reg <= imem_req;
            if (imem_req) resp_pc_reg <= pc_reg;
            if (redirect_valid) begin
                pc_reg    <= redirect_pc_aligned;
                count_reg <= 2'd0;
                drop_reg  <= inflight_reg;
            end else begin
                if (imem_req) pc_reg <= pc_reg + 32'd4;
                count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
                drop_reg  <= 1'b0;
            end
        end
    end

    // Buffer entries: entry 0 is the head; a pop shifts entry 1 down,
    // and a push writes the first slot free after that shift
    generate
        for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    buf_instr_reg[gi] <= 32'h0;
                    buf_pc_reg[gi]    <= 32'h0;
                end else if (push && (wr_idx == 2'(gi))) begin
                    buf_instr_reg[gi] <= imem_rdata;
                    buf_pc_reg[gi]    <= resp_pc_reg;
                end else if (shift && (gi == 0)) begin
                    buf_instr_reg[gi] <= buf_instr_reg[BUF_DEPTH-1];
                    buf_pc_reg[gi]    <= buf_pc_reg[BUF_DEPTH-1];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a cycle table for streaming, back-pressure,
// redirect and fetch_en drop, followed by hand-written sequences for field
// decode, PC wrap and asynchronous reset mid-stream.
`timescale 1ns/1ps

module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [5:0]  Op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  Func;

    int checks = 0;
    int errors = 0;

    instr_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .Op(Op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .Func(Func)
    );

    always #5 clk = ~clk;

    // Memory contents: one add instruction at 0x40, otherwise address + 0x100
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h40) return 32'h012A4020;
        return a + 32'h100;
    endfunction

    // Synchronous memory; garbage on cycles that do not follow a request
    always @(posedge clk) imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        fe, rdy, rv;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        ov;
        logic [31:0] opc, oin;
    } vec_t;

    function automatic vec_t mk(input logic fe, input logic rdy, input logic rv,
                                input logic [31:0] rpc, input logic req,
                                input logic [31:0] addr, input logic ov,
                                input logic [31:0] opc, input logic [31:0] oin);
        vec_t v;
        v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.req = req;
        v.addr = addr; v.ov = ov; v.opc = opc; v.oin = oin;
        return v;
    endfunction

    vec_t tbl [20];

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // fe rdy rv rpc | req addr | ov out_pc out_instr
        tbl[0]  = mk(1, 1, 0, 0,      0, 32'h000, 0, 32'h000, 32'h000); // IDLE -> RUN
        tbl[1]  = mk(1, 1, 0, 0,      1, 32'h000, 0, 32'h000, 32'h000);
        tbl[2]  = mk(1, 1, 0, 0,      1, 32'h004, 0, 32'h000, 32'h000);
        tbl[3]  = mk(1, 1, 0, 0,      1, 32'h008, 1, 32'h000, 32'h100); // 2 cycles after first req
        tbl[4]  = mk(1, 1, 0, 0,      1, 32'h00C, 1, 32'h004, 32'h104);
        tbl[5]  = mk(1, 0, 0, 0,      0, 32'h010, 1, 32'h008, 32'h108); // stall begins
        tbl[6]  = mk(1, 0, 0, 0,      0, 32'h010, 1, 32'h008, 32'h108); // full
        tbl[7]  = mk(1, 0, 0, 0,      0, 32'h010, 1, 32'h008, 32'h108);
        tbl[8]  = mk(1, 0, 0, 0,      0, 32'h010, 1, 32'h008, 32'h108);
        tbl[9]  = mk(1, 0, 0, 0,      0, 32'h010, 1, 32'h008, 32'h108);
        tbl[10] = mk(1, 1, 0, 0,      1, 32'h010, 1, 32'h008, 32'h108); // release
        tbl[11] = mk(1, 1, 0, 0,      1, 32'h014, 1, 32'h00C, 32'h10C);
        tbl[12] = mk(1, 1, 0, 0,      1, 32'h018, 1, 32'h010, 32'h110);
        tbl[13] = mk(1, 1, 1, 32'h403,0, 32'h01C, 1, 32'h014, 32'h114); // redirect + pop + inflight
        tbl[14] = mk(1, 1, 0, 0,      1, 32'h400, 0, 32'h000, 32'h000);
        tbl[15] = mk(1, 1, 0, 0,      1, 32'h404, 0, 32'h000, 32'h000);
        tbl[16] = mk(1, 1, 0, 0,      1, 32'h408, 1, 32'h400, 32'h500);
        tbl[17] = mk(0, 1, 0, 0,      0, 32'h40C, 1, 32'h404, 32'h504); // fetch_en drop
        tbl[18] = mk(0, 1, 0, 0,      0, 32'h40C, 1, 32'h408, 32'h508); // in-flight still captured
        tbl[19] = mk(0, 1, 0, 0,      0, 32'h40C, 0, 32'h000, 32'h000);

        reset_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; out_ready = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("reset_out_valid", {31'b0, out_valid}, 32'h0);
        chk("reset_imem_req",  {31'b0, imem_req},  32'h0);
        chk("reset_out_pc",    out_pc,    32'h0);
        chk("reset_out_instr", out_instr, 32'h0);
        chk("reset_fields", {Op, rs, rt, rd, shamt, Func}, 32'h0);
        next_cycle();
        reset_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            fetch_en = tbl[i].fe; out_ready = tbl[i].rdy;
            redirect_valid = tbl[i].rv; redirect_pc = tbl[i].rpc;
            @(negedge clk);
            chk($sformatf("row%0d_req", i),   {31'b0, imem_req},  {31'b0, tbl[i].req});
            chk($sformatf("row%0d_addr", i),  imem_addr,          tbl[i].addr);
            chk($sformatf("row%0d_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].ov});
            chk($sformatf("row%0d_pc", i),    out_pc,             tbl[i].opc);
            chk($sformatf("row%0d_instr", i), out_instr,          tbl[i].oin);
            $display("row %0d req=%0b addr=%h valid=%0b pc=%h instr=%h",
                     i, imem_req, imem_addr, out_valid, out_pc, out_instr);
            next_cycle();
        end

        // Field decode: redirect to the add instruction, hold it at the head
        fetch_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40; out_ready = 1'b0;
        @(negedge clk);
        chk("dec_redirect_req", {31'b0, imem_req}, 32'h0);
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("dec_req_addr", imem_addr, 32'h40);
        chk("dec_req", {31'b0, imem_req}, 32'h1);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("dec_valid", {31'b0, out_valid}, 32'h1);
        chk("dec_pc",    out_pc,    32'h40);
        chk("dec_Op",    {26'b0, Op},    32'd0);
        chk("dec_rs",    {27'b0, rs},    32'd9);
        chk("dec_rt",    {27'b0, rt},    32'd10);
        chk("dec_rd",    {27'b0, rd},    32'd8);
        chk("dec_shamt", {27'b0, shamt}, 32'd0);
        chk("dec_Func",  {26'b0, Func},  32'h20);
        $display("decode pc=%h Op=%0d rs=%0d rt=%0d rd=%0d shamt=%0d Func=%h",
                 out_pc, Op, rs, rt, rd, shamt, Func);
        next_cycle();

        // PC wrap: redirect to the last word (low bits ignored)
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE; out_ready = 1'b1;
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("wrap_req",   {31'b0, imem_req}, 32'h1);
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_flush", {31'b0, out_valid}, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("wrap_addr1", imem_addr, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("wrap_pc0",    out_pc,    32'hFFFF_FFFC);
        chk("wrap_instr0", out_instr, 32'h0000_00FC);
        next_cycle();
        @(negedge clk);
        chk("wrap_pc1",    out_pc,    32'h0);
        chk("wrap_instr1", out_instr, 32'h100);
        $display("wrap pc=%h instr=%h valid=%0b", out_pc, out_instr, out_valid);

        // Asynchronous reset between edges, held over one rising edge
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", {31'b0, out_valid}, 32'h0);
        chk("arst_req",   {31'b0, imem_req},  32'h0);
        chk("arst_pc",    out_pc, 32'h0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        #1;
        chk("arst_idle_addr", imem_addr, 32'h0);
        chk("arst_idle_req",  {31'b0, imem_req}, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("arst_restart_req",  {31'b0, imem_req}, 32'h1);
        chk("arst_restart_addr", imem_addr, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("arst_addr4",  imem_addr, 32'h4);
        chk("arst_empty",  {31'b0, out_valid}, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("arst_first_valid", {31'b0, out_valid}, 32'h1);
        chk("arst_first_pc",    out_pc,    32'h0);
        chk("arst_first_instr", out_instr, 32'h100);
        $display("restart pc=%h instr=%h valid=%0b", out_pc, out_instr, out_valid);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
